// File: rtl/alu_pkg.sv
// Shared ALU operation codes, used by the ALU datapath and the ALU control decoder.
package alu_pkg;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: second-operand mux, operation select and zero detect.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] imm,
   input  logic             alu_src,
   input  logic [3:0]       ALUCtl,
   output logic [WIDTH-1:0] result_next,
   output logic             zero_next
);
   logic [WIDTH-1:0] op2;
   logic [4:0]       shamt;
   logic             lt_signed;
   logic             lt_unsigned;

   assign op2         = alu_src ? imm : B;
   assign shamt       = op2[4:0];
   assign lt_signed   = $signed(A) < $signed(op2);
   assign lt_unsigned = A < op2;

   always_comb begin
      result_next = '0;
      case (ALUCtl)
         ALU_AND:  result_next = A & op2;
         ALU_OR:   result_next = A | op2;
         ALU_ADD:  result_next = A + op2;
         ALU_XOR:  result_next = A ^ op2;
         ALU_SLL:  result_next = A << shamt;
         ALU_SRL:  result_next = A >> shamt;
         ALU_SUB:  result_next = A - op2;
         ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
         ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
         ALU_SRA:  result_next = WIDTH'($signed(A) >>> shamt);
         ALU_NOR:  result_next = ~(A | op2);
         default:  result_next = '0;
      endcase
   end

   // Derived from the same value that gets registered, so result and zero never disagree.
   assign zero_next = (result_next == '0);
endmodule

// File: rtl/alu_v_32.sv
// 32-bit RISC-V ALU with registered result and zero flag (one-cycle latency).
module alu_v_32
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] imm,
   input  logic             alu_src,
   input  logic [3:0]       ALUCtl,
   output logic             zero,
   output logic [WIDTH-1:0] result
);
   logic [WIDTH-1:0] result_next;
   logic             zero_next;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .A           (A),
      .B           (B),
      .imm         (imm),
      .alu_src     (alu_src),
      .ALUCtl      (ALUCtl),
      .result_next (result_next),
      .zero_next   (zero_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b1;
      end else begin
         result <= result_next;
         zero   <= zero_next;
      end
   end
endmodule

// File: tb/tb_alu_v_32.sv
// Self-checking bench for alu_v_32: directed cases plus randomized traffic against a reference model.
module tb_alu_v_32;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B, imm;
   logic        alu_src;
   logic [3:0]  ALUCtl;
   logic        zero;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   alu_v_32 dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .imm     (imm),
      .alu_src (alu_src),
      .ALUCtl  (ALUCtl),
      .zero    (zero),
      .result  (result)
   );

   always #5 clk = ~clk;

   // Reference model: each operation written straight from its arithmetic meaning.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] i, input logic src,
                                         input logic [3:0] ctl);
      logic [31:0] y;
      int unsigned sh;
      longint      sa, sy;
      y  = src ? i : b;
      sh = y % 32;
      sa = longint'($signed(a));
      case (ctl)
         4'd0:  return a & y;
         4'd1:  return a | y;
         4'd2:  return 32'(longint'(a) + longint'(y));
         4'd3:  return a ^ y;
         4'd4:  return 32'(longint'(a) * (longint'(1) << sh));
         4'd5:  return 32'(longint'(a) / (longint'(1) << sh));
         4'd6:  return 32'(longint'(a) - longint'(y));
         4'd7:  return (sa < longint'($signed(y))) ? 32'd1 : 32'd0;
         4'd8:  return (longint'(a) < longint'(y)) ? 32'd1 : 32'd0;
         4'd9: begin
            // floor division by 2^sh equals arithmetic shift right
            sy = sa / (longint'(1) << sh);
            if (sa < 0 && (sa % (longint'(1) << sh)) != 0) sy = sy - 1;
            return 32'(sy);
         end
         4'd12: return ~(a | y);
         default: return 32'd0;
      endcase
   endfunction

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                        input logic src, input logic [3:0] ctl);
      @(negedge clk);
      A = a; B = b; imm = i; alu_src = src; ALUCtl = ctl;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      rst = 1'b1;
      A = 32'd6; B = 32'd5; imm = 32'd7; alu_src = 1'b0; ALUCtl = 4'b0010;
      #1;
      total++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL reset_initial result=%h zero=%b want 00000000/1", result, zero);
      end
      @(negedge clk); rst = 1'b0;
      apply(32'd6, 32'd5, 32'd7, 1'b0, 4'b0010);
      total++;
      if (result !== 32'hB || zero !== 1'b0) begin
         bad++;
         $display("FAIL pre_reset_add result=%h zero=%b want 0000000b/0", result, zero);
      end
      // assert mid-cycle, away from any edge
      #2 rst = 1'b1;
      #1;
      total++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL reset_async result=%h zero=%b want 00000000/1", result, zero);
      end
      A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALUCtl = 4'b0001;
      @(posedge clk); #1;
      total++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL reset_hold result=%h zero=%b want 00000000/1", result, zero);
      end
      @(negedge clk); rst = 1'b0;
      #1;
      total++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_hold result=%h zero=%b want 00000000/1", result, zero);
      end
      exp = 32'hDEAD_BEEF | 32'h1234_5678;
      @(posedge clk); #1;
      total++;
      if (result !== exp || zero !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_result result=%h zero=%b want %h/0", result, zero, exp);
      end
      $display("reset test: async clear, hold and first result checked");
   endtask

   task automatic test_operands();
      logic [3:0]  ctls [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1111};
      logic [31:0] exp_reg [5] = '{32'd4, 32'd7, 32'hB, 32'd1, 32'd0};
      logic [31:0] exp_imm [5] = '{32'd6, 32'd7, 32'hD, 32'hFFFF_FFFF, 32'd0};
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 5; k++) begin
            logic [31:0] e;
            e = (s == 0) ? exp_reg[k] : exp_imm[k];
            apply(32'd6, 32'd5, 32'd7, s[0], ctls[k]);
            total++;
            if (result !== e || zero !== (e == 32'd0)) begin
               bad++;
               $display("FAIL operand_src%0d_ctl%b result=%h zero=%b want %h/%b",
                        s, ctls[k], result, zero, e, e == 32'd0);
            end
            $display("op src=%0d ctl=%b result=%h zero=%b", s, ctls[k], result, zero);
         end
      end
   endtask

   task automatic test_compare();
      apply(32'hFFFF_FFFF, 32'd1, 32'd7, 1'b0, 4'b0111);
      total++;
      if (result !== 32'd1 || zero !== 1'b0) begin
         bad++;
         $display("FAIL slt result=%h zero=%b want 00000001/0", result, zero);
      end
      $display("slt result=%h", result);
      apply(32'hFFFF_FFFF, 32'd1, 32'd7, 1'b0, 4'b1000);
      total++;
      if (result !== 32'd0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL sltu result=%h zero=%b want 00000000/1", result, zero);
      end
      $display("sltu result=%h", result);
      apply(32'h1234, 32'h1234, 32'd7, 1'b0, 4'b0110);
      total++;
      if (result !== 32'd0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL sub_equal result=%h zero=%b want 00000000/1", result, zero);
      end
      $display("sub equal result=%h zero=%b", result, zero);
   endtask

   task automatic test_shifts();
      logic [31:0] amts [2] = '{32'd4, 32'h24};
      logic [3:0]  ctls [3] = '{4'b0100, 4'b0101, 4'b1001};
      logic [31:0] exps [3] = '{32'h0000_0100, 32'h0800_0001, 32'hF800_0001};
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < 3; k++) begin
            apply(32'h8000_0010, amts[a], 32'd7, 1'b0, ctls[k]);
            total++;
            if (result !== exps[k] || zero !== 1'b0) begin
               bad++;
               $display("FAIL shift_b%h_ctl%b result=%h zero=%b want %h/0",
                        amts[a], ctls[k], result, zero, exps[k]);
            end
            $display("shift b=%h ctl=%b result=%h", amts[a], ctls[k], result);
         end
      end
      apply(32'h8000_0010, 32'hFFFF_FFE0, 32'd7, 1'b0, 4'b1001);
      total++;
      if (result !== 32'h8000_0010) begin
         bad++;
         $display("FAIL shift_zero_amount result=%h want 80000010", result);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 16; c++) begin
         logic [31:0] a, b, e;
         a = $urandom; b = $urandom;
         e = model(a, b, 32'd0, 1'b0, 4'(c));
         apply(a, b, 32'd0, 1'b0, 4'(c));
         total++;
         if (result !== e || zero !== (e == 32'd0)) begin
            bad++;
            $display("FAIL b2b_ctl%0d result=%h zero=%b want %h/%b", c, result, zero, e, e == 32'd0);
         end
         $display("b2b ctl=%0d a=%h b=%h result=%h", c, a, b, result);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a, b, i, e;
         logic        s;
         logic [3:0]  c;
         a = $urandom; b = $urandom; i = $urandom;
         if (n % 4 == 0) b = a;
         if (n % 8 == 1) a = {1'b1, 31'(a)};
         s = 1'($urandom);
         c = 4'($urandom);
         e = model(a, b, i, s, c);
         apply(a, b, i, s, c);
         total++;
         if (result !== e || zero !== (e == 32'd0)) begin
            bad++;
            $display("FAIL random%0d ctl=%b src=%b result=%h zero=%b want %h/%b",
                     n, c, s, result, zero, e, e == 32'd0);
         end
         $display("rand %0d ctl=%b src=%b a=%h op=%h result=%h", n, c, s, a, s ? i : b, result);
      end
   endtask

   initial begin
      test_reset();
      test_operands();
      test_compare();
      test_shifts();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
